multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute for lw, sw, addu, ori, lui, j.
// Latency: Moore outputs from the state register; lw 5, sw 4, addu/ori/lui 4, j 3 cycles with no wait states.
// Stalls: FETCH, MEMRD and MEMWR hold until mem_ready; illegal encodings park in HALT until reset.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   opcode, funct       IR fields instr[31:26] and instr[5:0]
//   mem_ready           memory completes the pending access this cycle
//   mem_req/mem_we/iord memory request, write strobe, address select (0=PC, 1=ALUOut)
//   ir_write/pc_write   IR load, PC load
//   reg_write/reg_dst/mem_to_reg  register file write controls
//   alu_src_a/alu_src_b/aluop     ALU operand and operation selects
//   pc_src              next-PC select (00=ALU, 10=jump target)
//   state/halted/instr_count      debug state code, trap flag, retired-instruction count
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  aluop,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ORI = 3'b001;
  localparam logic [2:0] ALU_LUI = 3'b000;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_ORIEXE = 4'd8,
    S_LUIEXE = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   retire;     // high on the cycle whose edge completes an instruction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Natural 32-bit wrap; HALT never raises retire so the count freezes there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 32'd0;
    end else if (retire) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    aluop      = 3'b000;
    pc_src     = 2'b00;
    halted     = 1'b0;

    case (cur_state)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed with the IR on mem_ready.
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        aluop     = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nxt_state = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = (funct == FN_ADDU) ? S_RTEXE : S_HALT;
          OP_ORI:       nxt_state = S_ORIEXE;
          OP_LUI:       nxt_state = S_LUIEXE;
          OP_J:         nxt_state = S_JUMP;
          default:      nxt_state = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        aluop     = ALU_ADD;
        nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        nxt_state  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_RTEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        aluop     = ALU_ADD;
        nxt_state = S_RTWB;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_ORIEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_ZEXT;
        aluop     = ALU_ORI;
        nxt_state = S_IMMWB;
      end
      S_LUIEXE: begin
        // LUI ignores operand A, so alu_src_a stays at its default.
        alu_src_b = SRCB_ZEXT;
        aluop     = ALU_LUI;
        nxt_state = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = PCSRC_JUMP;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_HALT: begin
        halted    = 1'b1;
        nxt_state = S_HALT;
      end
      default: begin
        // Unused codes 13..15 are unreachable; recover to a clean fetch.
        nxt_state = S_FETCH;
      end
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios with literal expectations plus a
// randomized instruction/wait-state stream checked every cycle against a route-table
// model (instruction class -> list of state codes, wait states gated by mem_ready).
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  aluop;
  logic [1:0]  pc_src;
  logic [3:0]  state;
  logic        halted;
  logic [31:0] instr_count;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .pc_src     (pc_src),
    .state      (state),
    .halted     (halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state = 0;
  logic [31:0] m_count = 32'd0;
  logic [31:0] m_bias  = 32'd0;   // offset applied when the bench preloads the counter
  int          m_plan[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0;
      m_count = 32'd0;
      m_plan.delete();
    end else if (m_state == 12) begin
      m_state = 12;
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
      m_state = m_state;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (opcode == 6'b100011)                         m_plan = '{2, 3, 4};
      else if (opcode == 6'b101011)                    m_plan = '{2, 5};
      else if (opcode == 6'b000000 && funct == 6'h21)  m_plan = '{6, 7};
      else if (opcode == 6'b001101)                    m_plan = '{8, 10};
      else if (opcode == 6'b001111)                    m_plan = '{9, 10};
      else if (opcode == 6'b000010)                    m_plan = '{11};
      else                                             m_plan = '{12};
      m_state = m_plan.pop_front();
    end else if (m_plan.size() != 0) begin
      m_state = m_plan.pop_front();
    end else begin
      m_state = 0;
      m_count = m_count + 32'd1;
    end
  end

  // Control word per state: {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
  // reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], aluop[2:0], pc_src[1:0]}
  function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
    logic mq, we, io, irw, pcw, rw, rd, m2r, sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic [1:0] ps;
    mq = 0; we = 0; io = 0; irw = 0; pcw = 0; rw = 0; rd = 0; m2r = 0; sa = 0;
    sb = 2'b00; op = 3'b000; ps = 2'b00;
    case (s)
      0:  begin mq = 1; sb = 2'b01; op = 3'b010; irw = mr; pcw = mr; end
      2:  begin sa = 1; sb = 2'b10; op = 3'b010; end
      3:  begin mq = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mq = 1; we = 1; io = 1; end
      6:  begin sa = 1; sb = 2'b00; op = 3'b010; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; sb = 2'b11; op = 3'b001; end
      9:  begin sb = 2'b11; op = 3'b000; end
      10: begin rw = 1; end
      11: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {mq, we, io, irw, pcw, rw, rd, m2r, sa, sb, op, ps};
  endfunction

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_state",  32'(state), 32'(m_state));
    chk("cyc_halted", 32'(halted), 32'(m_state == 12));
    chk("cyc_count",  instr_count, m_count + m_bias);
    chk("cyc_ctrl",
        32'({mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, aluop, pc_src}),
        32'(exp_ctrl(m_state, mem_ready)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic mr);
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m_bias = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH with no wait states; returns cycles until FETCH/HALT.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, output int cycles);
    opcode = op;
    funct  = fn;
    cycles = 0;
    do begin
      cyc(1'b1);
      cycles++;
    end while (state != 4'd0 && state != 4'd12 && cycles < 20);
  endtask

  initial begin
    int cycles;
    int held;
    int rd_cnt;
    int hcnt;
    logic mr;
    int k;

    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    funct = 6'd0;
    #3;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_memreq", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // addu: 0,1,6,7,0
    opcode = 6'b000000;
    funct  = 6'b100001;
    cyc(1'b1); chk("addu_s1", 32'(state), 32'd1);
    cyc(1'b1); chk("addu_s6", 32'(state), 32'd6);
    chk("addu_rw6", 32'(reg_write), 32'd0);
    cyc(1'b1); chk("addu_s7", 32'(state), 32'd7);
    chk("addu_rw7", 32'({reg_write, reg_dst}), 32'd3);
    cyc(1'b1); chk("addu_s0", 32'(state), 32'd0);
    chk("addu_count", instr_count, 32'd1);

    // lw with three wait cycles in MEMRD
    opcode = 6'b100011;
    cycles = 0;
    held = 0;
    rd_cnt = 0;
    do begin
      if (state == 4'd3) begin
        if (mem_req && iord) held++;
        mr = (rd_cnt == 3);
        rd_cnt++;
      end else begin
        mr = (state == 4'd0);
      end
      if (state == 4'd4) chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
      cyc(mr);
      cycles++;
    end while (state != 4'd0 && cycles < 20);
    chk("lw_cycles", 32'(cycles), 32'd8);
    chk("lw_held", 32'(held), 32'd4);
    chk("lw_count", instr_count, 32'd2);

    // zero-wait-state cycle counts
    run_instr(6'b101011, 6'd0, cycles); chk("sw_cycles", 32'(cycles), 32'd4);
    run_instr(6'b000000, 6'h21, cycles); chk("addu_cycles", 32'(cycles), 32'd4);
    run_instr(6'b000010, 6'd0, cycles); chk("j_cycles", 32'(cycles), 32'd3);

    // ori then lui
    do_reset();
    opcode = 6'b001101;
    cyc(1'b1); cyc(1'b0);
    chk("ori_state", 32'(state), 32'd8);
    chk("ori_alu", 32'({alu_src_a, alu_src_b, aluop}), 32'b1_11_001);
    cyc(1'b0); cyc(1'b0);
    opcode = 6'b001111;
    cyc(1'b1); cyc(1'b0);
    chk("lui_state", 32'(state), 32'd9);
    chk("lui_alu", 32'({alu_src_b, aluop}), 32'b11_000);
    cyc(1'b0); cyc(1'b0);
    chk("orilui_count", instr_count, 32'd2);

    // illegal opcode traps in cycle 3
    do_reset();
    opcode = 6'b111111;
    cyc(1'b1); cyc(1'b1);
    chk("halt_state", 32'(state), 32'd12);
    chk("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'($urandom_range(0, 1)));
      chk("halt_quiet", 32'({mem_req, mem_we, ir_write, pc_write, reg_write}), 32'd0);
    end
    chk("halt_stays", 32'(state), 32'd12);

    // reset mid-MEMWR abandons the store
    do_reset();
    run_instr(6'b000010, 6'd0, cycles);
    opcode = 6'b101011;
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    chk("sw_in_memwr", 32'({state, mem_we}), 32'({4'd5, 1'b1}));
    #2;
    reset  = 1'b1;
    m_bias = 32'd0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_memwe", 32'(mem_we), 32'd0);
    chk("async_fetch", 32'({mem_req, iord}), 32'b10);
    chk("async_count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1);
    chk("post_reset_decode", 32'(state), 32'd1);
    cyc(1'b0); cyc(1'b0); cyc(1'b1);

    // counter wrap on a jump
    do_reset();
    force dut.instr_count = 32'hFFFF_FFFF;
    m_bias = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count;
    #1;
    chk("preload", instr_count, 32'hFFFF_FFFF);
    run_instr(6'b000010, 6'd0, cycles);
    chk("wrap_count", instr_count, 32'd0);

    // randomized stream
    do_reset();
    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_state == 0) begin
        k = $urandom_range(0, 15);
        funct = 6'($urandom);
        case (k)
          0, 1, 2, 15: opcode = 6'b100011;
          3, 4:        opcode = 6'b101011;
          5, 6:        begin opcode = 6'b000000; funct = 6'h21; end
          7, 8:        opcode = 6'b001101;
          9, 10:       opcode = 6'b001111;
          11, 12:      opcode = 6'b000010;
          13:          begin opcode = 6'b000000; if (funct == 6'h21) funct = 6'h20; end
          default:     opcode = 6'($urandom);
        endcase
      end
      if (m_state == 12) hcnt++;
      if (hcnt > 3 || $urandom_range(0, 199) == 0) begin
        hcnt   = 0;
        reset  = 1'b1;
        m_bias = 32'd0;
        #2;
        reset  = 1'b0;
      end
      cyc(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
